wb_target_mem: RTL
==================

Name: wb_target_mem

Overview:
- Wishbone classic target: word-addressed on-chip memory that consumes transfers from wb_initiator_bfm.
- Replaces ad-hoc single-register responders in DV benches.
- Programmable wait states, byte-lane writes, error response for out-of-range addresses.
- Sits directly downstream of the initiator and connects through the standard wishbone wire bundle.

Parameters:
- ADDR_WIDTH, 32: width of adr.
- DATA_WIDTH, 32: width of dat_w/dat_r. Must be a multiple of 8.
- MEM_WORDS, 256: number of DATA_WIDTH words of storage.
- WAIT_STATES, 0: extra cycles inserted between request capture and ack/err. Range 0..15.

Ports:
- clock  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- adr    input  ADDR_WIDTH  byte address.
- dat_w  input  DATA_WIDTH  write data.
- dat_r  output DATA_WIDTH  read data, valid while ack=1.
- cyc    input  1  bus cycle active.
- stb    input  1  strobe.
- we     input  1  1=write, 0=read.
- sel    input  DATA_WIDTH/8  byte-lane enables.
- ack    output 1  normal termination.
- err    output 1  error termination.

Behaviour:
- Reset (asynchronous assert, synchronous deassert is the integrator's job):
  - state=IDLE, ack=0, err=0, dat_r=0, wait counter=0.
  - Memory contents are not cleared.
- Word index = adr >> log2(DATA_WIDTH/8). Low address bits are ignored. Index >= MEM_WORDS is out of range.
- FSM states:
  - IDLE: on cyc&stb, capture adr/we/sel/dat_w. Go to WAIT if WAIT_STATES>0 (counter loads WAIT_STATES-1), else RESP.
  - WAIT: counter decrements each cycle. At 0 go to RESP. If cyc=0 or stb=0, abort to IDLE: no write, no ack.
  - RESP: exactly one cycle of ack=1 (in range) or err=1 (out of range), then IDLE unconditionally.
- ack and err are mutually exclusive and never high in IDLE or WAIT.
- Latency: request sampled at edge N, ack/err high during cycle N+1+WAIT_STATES.
- Throughput is at most 1 transfer per 2 cycles. A request held high across the RESP cycle is treated as a new request in the following IDLE cycle.
- Write commit:
  - Occurs on the edge entering RESP, only for in-range addresses.
  - Byte lane b is written iff sel[b]=1. sel=0 writes nothing but still acks.
- Read:
  - dat_r = memory word during RESP with ack.
  - dat_r = 0 in every other cycle, including err cycles.
  - Read-after-write to the same word returns the new data.
- cyc drop during RESP does not cancel the ack cycle (already committed).
- Reset asserted mid-transfer: immediate IDLE, ack/err drop asynchronously. A write not yet committed is lost.

Optional Feature:
- Macro: WB_TARGET_MEM_STATS_EN.
- When defined, adds three 32-bit output ports:
  - rd_count: increments on each ack with we=0.
  - wr_count: increments on each ack with we=1.
  - err_count: increments on each err.
- Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Package wb_target_mem_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP).
  - Width of the wait counter (4 bits).
  - Function computing the byte-lane shift, log2(DATA_WIDTH/8).
- Sub-module wb_target_mem_ram:
  - Single-port storage array with byte-enable write and synchronous read.
  - Parameters DATA_WIDTH and MEM_WORDS.
  - No reset.
- wb_target_mem instantiates wb_target_mem_ram once and owns the FSM and address decode.

Test Plan:
1. WAIT_STATES=0: write adr=0x10, dat_w=0xDEADBEEF, sel=0xF, then read adr=0x10 -> ack exactly 1 cycle after each request, dat_r=0xDEADBEEF, err never high.
2. Byte lanes: write 0xFFFFFFFF sel=0xF to adr=0x20, then 0x00000000 sel=0x5 -> read returns 0xFF00FF00.
3. WAIT_STATES=3: read adr=0x4 -> ack in the 4th cycle after request edge, ack width 1. Drop stb after 2 cycles on a second write -> no ack, memory unchanged.
4. Out of range, MEM_WORDS=256: write adr=0x400 -> err 1 cycle, ack=0, dat_r=0. Then read adr=0x0 still returns its prior value.
5. Reset mid-transfer: assert reset during WAIT of a write to adr=0x8 -> ack/err low immediately. Post-reset read of 0x8 shows old data.
6. WB_TARGET_MEM_STATS_EN: 3 writes, 2 reads, 1 error -> wr_count=3, rd_count=2, err_count=1. Reset -> all 0.

Source files
------------

// File: rtl/wb_target_mem_pkg.sv
// wb_target_mem shared types: FSM state, wait counter width,
// and the byte-lane shift helper used for word indexing.
package wb_target_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;

  function automatic int lane_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/wb_target_mem_ram.sv
// Single-port byte-enable storage with synchronous read.
// Written lanes are forwarded to the read register (write-first).
module wb_target_mem_ram
  import wb_target_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  wr,
  input  logic [AW-1:0]         addr,
  input  logic [NB-1:0]         be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // per-lane write plus registered read of the addressed word
  always_ff @(posedge clock) begin
    if (en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr && be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          rdata[b*8 +: 8]     <= wdata[b*8 +: 8];
        end else begin
          rdata[b*8 +: 8] <= mem[addr][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/wb_target_mem.sv
// Wishbone classic target memory with programmable wait states.
// Optional WB_TARGET_MEM_STATS_EN adds rd/wr/err transfer counters.
module wb_target_mem
  import wb_target_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic [DATA_WIDTH-1:0]   dat_r,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  output logic                    ack,
  output logic                    err
`ifdef WB_TARGET_MEM_STATS_EN
  ,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count,
  output logic [31:0]             err_count
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int SHIFT = lane_shift(DATA_WIDTH);
  localparam int AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(MEM_WORDS);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t state;
  state_t state_nx;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [WAIT_CNT_W-1:0] cnt_nx;

  logic                  req;
  logic [ADDR_WIDTH-1:0] idx_live;
  logic                  hit_live;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  we_q;
  logic [NB-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  hit_q;

  logic [ADDR_WIDTH-1:0] cur_idx;
  logic                  cur_we;
  logic [NB-1:0]         cur_sel;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic                  cur_hit;

  logic                  commit;
  logic                  ram_wr;
  logic [DATA_WIDTH-1:0] ram_q;

  assign req      = cyc & stb;
  assign idx_live = adr >> SHIFT;
  assign hit_live = idx_live < LIMIT;

  // IDLE looks at the live bus, later states at the captured request
  always_comb begin
    cur_idx = idx_q;
    cur_we  = we_q;
    cur_sel = sel_q;
    cur_dat = dat_q;
    cur_hit = hit_q;
    if (state == IDLE) begin
      cur_idx = idx_live;
      cur_we  = we;
      cur_sel = sel;
      cur_dat = dat_w;
      cur_hit = hit_live;
    end
  end

  assign commit = (state_nx == RESP);
  assign ram_wr = commit & cur_we & cur_hit;

  wb_target_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clock (clock),
    .en    (state != RESP),
    .wr    (ram_wr),
    .addr  (cur_idx[AW-1:0]),
    .be    (cur_sel),
    .wdata (cur_dat),
    .rdata (ram_q)
  );

  // state and wait counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next state: capture, count down or abort, then one response cycle
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end else begin
            state_nx = RESP;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == '0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // request capture on acceptance in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      hit_q <= 1'b0;
    end else if (state == IDLE && req) begin
      idx_q <= idx_live;
      we_q  <= we;
      sel_q <= sel;
      dat_q <= dat_w;
      hit_q <= hit_live;
    end
  end

  assign ack   = (state == RESP) &  hit_q;
  assign err   = (state == RESP) & ~hit_q;
  assign dat_r = ack ? ram_q : '0;

`ifdef WB_TARGET_MEM_STATS_EN
  // saturating transfer counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (ack && !we_q && rd_count != '1)
        rd_count <= rd_count + 32'd1;
      if (ack && we_q && wr_count != '1)
        wr_count <= wr_count + 32'd1;
      if (err && err_count != '1)
        err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule
